multdiv_sched: RTL

//  Scheduler for the shared iterative multdiv unit. Issues mul/div from DX as single-cycle ctrl pulses and tracks the in-flight op.

---
 rtl/multdiv_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/multdiv_sched.sv
// Issue/stall/commit scheduler for the shared iterative multdiv unit.
// Tracks one in-flight mul/div and arbitrates the regfile write port against MW writeback.
module multdiv_sched #(
   parameter int          TIMEOUT = 40,
   parameter logic [31:0] EXC_MUL = 32'd4,
   parameter logic [31:0] EXC_DIV = 32'd5,
   parameter logic [31:0] EXC_TMO = 32'd7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dx_ir,
   input  logic        mw_we,
   input  logic        md_ready,
   input  logic        md_exception,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        md_issue,
   output logic        md_stall,
   output logic        busy,
   output logic        commit,
   output logic        commit_exc,
   output logic [4:0]  commit_reg,
   output logic [31:0] exc_code,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_WAIT_WB = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [4:0]    p_rd_q, p_rd_d;
   logic          p_div_q, p_div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          p_exc_q, p_exc_d;
   logic          p_tmo_q, p_tmo_d;

   logic [4:0] op, aluop, rd, rs, rt;
   logic       dx_mul, dx_div, dx_md;
   logic       reads_rs, reads_rt, reads_rd, writes_rd, hazard;
   logic       fire, res_exc, res_tmo;
   logic       unused_ir_bits;

   assign op     = dx_ir[31:27];
   assign rd     = dx_ir[26:22];
   assign rs     = dx_ir[21:17];
   assign rt     = dx_ir[16:12];
   assign aluop  = dx_ir[6:2];
   assign dx_mul = (op == 5'b00000) && (aluop == 5'b00110);
   assign dx_div = (op == 5'b00000) && (aluop == 5'b00111);
   assign dx_md  = dx_mul | dx_div;
   assign unused_ir_bits = ^{dx_ir[11:7], dx_ir[1:0]};

   always_comb begin
      reads_rs  = op inside {5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110};
      reads_rt  = (op == 5'b00000);
      reads_rd  = op inside {5'b00111, 5'b00010, 5'b00110, 5'b00100};
      writes_rd = op inside {5'b00000, 5'b00101, 5'b01000};
      // r0 is never a real dependency, so a pending write to r0 cannot cause a hazard
      hazard    = (p_rd_q != 5'd0) &&
                  ((reads_rs && rs == p_rd_q) ||
                   (reads_rt && rt == p_rd_q) ||
                   ((reads_rd || writes_rd) && rd == p_rd_q));
   end

   always_comb begin
      state_d    = state_q;
      p_rd_d     = p_rd_q;
      p_div_d    = p_div_q;
      cnt_d      = cnt_q;
      p_exc_d    = p_exc_q;
      p_tmo_d    = p_tmo_q;
      fire       = 1'b0;
      res_exc    = 1'b0;
      res_tmo    = 1'b0;
      md_issue   = 1'b0;
      ctrl_MULT  = 1'b0;
      ctrl_DIV   = 1'b0;
      commit     = 1'b0;
      commit_exc = 1'b0;
      commit_reg = 5'd0;
      exc_code   = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (dx_md) begin
               md_issue  = 1'b1;
               ctrl_MULT = dx_mul;
               ctrl_DIV  = dx_div;
               state_d   = S_BUSY;
               p_rd_d    = rd;
               p_div_d   = dx_div;
               cnt_d     = '0;
               p_exc_d   = 1'b0;
               p_tmo_d   = 1'b0;
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (md_ready || cnt_q == CW'(TIMEOUT)) begin
               res_exc = md_ready ? md_exception : 1'b1;
               res_tmo = !md_ready;
               if (mw_we) begin
                  state_d = S_WAIT_WB;
                  p_exc_d = res_exc;
                  p_tmo_d = res_tmo;
               end else begin
                  fire    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT_WB: begin
            res_exc = p_exc_q;
            res_tmo = p_tmo_q;
            if (!mw_we) begin
               fire    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fire) begin
         if (res_exc) begin
            commit     = 1'b1;
            commit_exc = 1'b1;
            commit_reg = 5'd30;
            exc_code   = res_tmo ? EXC_TMO : (p_div_q ? EXC_DIV : EXC_MUL);
         end else if (p_rd_q != 5'd0) begin
            commit     = 1'b1;
            commit_reg = p_rd_q;
         end
      end

      busy     = (state_q != S_IDLE);
      md_stall = busy & (dx_md | hazard);

      // Reset must silence the combinational decode of dx_ir as well as the state-driven outputs
      if (reset) begin
         md_issue   = 1'b0;
         ctrl_MULT  = 1'b0;
         ctrl_DIV   = 1'b0;
         commit     = 1'b0;
         commit_exc = 1'b0;
         commit_reg = 5'd0;
         exc_code   = 32'd0;
         busy       = 1'b0;
         md_stall   = 1'b0;
      end
   end

   assign dbg_state = state_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         p_rd_q  <= 5'd0;
         p_div_q <= 1'b0;
         cnt_q   <= '0;
         p_exc_q <= 1'b0;
         p_tmo_q <= 1'b0;
      end else begin
         state_q <= state_d;
         p_rd_q  <= p_rd_d;
         p_div_q <= p_div_d;
         cnt_q   <= cnt_d;
         p_exc_q <= p_exc_d;
         p_tmo_q <= p_tmo_d;
      end
   end

endmodule
